// File: rtl/any1_rob_ctrl_if.sv
// Handshake bundle between the rename/dispatch side (master) and the
// reorder-buffer controller (slave): allocation, completion, commit, flush
// and occupancy status.
interface any1_rob_ctrl_if #(
  parameter int ENTRIES = 64,
  parameter int ENQ_W   = 2,
  parameter int CMT_W   = 2
);
  localparam int RIDW = $clog2(ENTRIES);
  localparam int AW   = $clog2(ENQ_W + 1);
  localparam int MW   = $clog2(CMT_W + 1);

  logic [AW-1:0]                alloc_cnt_i;
  logic                         alloc_gnt_o;
  logic [ENQ_W-1:0][RIDW-1:0]   alloc_rid_o;
  logic [ENTRIES-1:0]           done_v_i;
  logic                         cmt_stall_i;
  logic [MW-1:0]                cmt_cnt_o;
  logic [CMT_W-1:0][RIDW-1:0]   cmt_rid_o;
  logic                         flush_i;
  logic [RIDW-1:0]              flush_rid_i;
  logic                         empty_o;
  logic                         full_o;
  logic [RIDW:0]                count_o;

  modport master (
    output alloc_cnt_i, done_v_i, cmt_stall_i, flush_i, flush_rid_i,
    input  alloc_gnt_o, alloc_rid_o, cmt_cnt_o, cmt_rid_o, empty_o, full_o, count_o
  );

  modport slave (
    input  alloc_cnt_i, done_v_i, cmt_stall_i, flush_i, flush_rid_i,
    output alloc_gnt_o, alloc_rid_o, cmt_cnt_o, cmt_rid_o, empty_o, full_o, count_o
  );
endinterface

// File: rtl/any1_rob_ctrl.sv
// Reorder-buffer pointer/occupancy controller.
// Circular buffer of ENTRIES slots: multi-slot allocation at tail, in-order
// multi-slot retire at head, flush that truncates everything younger than a
// surviving rid. head==tail is disambiguated by count.
// Optional: define ANY1_ROB_PERF_EN to add a 64-bit retired-entry counter
// (perf_cmt_o).
module any1_rob_ctrl #(
  parameter int ENTRIES = 64,
  parameter int ENQ_W   = 2,
  parameter int CMT_W   = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  any1_rob_ctrl_if.slave        rob
`ifdef ANY1_ROB_PERF_EN
  ,
  output logic [63:0]           perf_cmt_o
`endif
);
  localparam int RIDW = $clog2(ENTRIES);
  localparam int CW   = RIDW + 1;
  localparam int XW   = CW + 1;
  localparam int AW   = $clog2(ENQ_W + 1);
  localparam int MW   = $clog2(CMT_W + 1);

  logic [RIDW-1:0]    head, tail;
  logic [CW-1:0]      count;
  logic [ENTRIES-1:0] valid, done;

  logic [MW-1:0]      cmt;
  logic               gnt;
  logic [AW-1:0]      alloc_eff;
  logic [XW-1:0]      room;
  logic [RIDW-1:0]    fr_off;
  logic [ENTRIES-1:0] ret_m, alc_m, sq_m;

  // Age of the last surviving entry relative to head.
  always_comb fr_off = rob.flush_rid_i - head;

  // Retire run: consecutive valid&done entries from head, capped at CMT_W.
  // In a flush cycle the run also stops at the flush point so a squashed
  // entry can never retire.
  always_comb begin
    logic            run;
    logic [RIDW-1:0] idx;
    cmt = '0;
    run = 1'b1;
    idx = '0;
    for (int k = 0; k < CMT_W; k++) begin
      idx = head + RIDW'(k);
      if (rob.flush_i && (RIDW'(k) > fr_off)) run = 1'b0;
      if (run && valid[idx] && done[idx]) cmt = cmt + MW'(1);
      else run = 1'b0;
    end
    if (rob.cmt_stall_i) cmt = '0;
  end

  // Grant when free slots, counting slots freed by this cycle's retire, cover the request.
  always_comb begin
    room      = XW'(ENTRIES) - XW'(count) + XW'(cmt);
    gnt       = (rob.alloc_cnt_i != '0) && !rob.flush_i && (room >= XW'(rob.alloc_cnt_i));
    alloc_eff = gnt ? rob.alloc_cnt_i : '0;
  end

  // Per-entry retire, allocate and squash masks.
  always_comb begin
    ret_m = '0;
    alc_m = '0;
    sq_m  = '0;
    for (int k = 0; k < CMT_W; k++)
      if (MW'(k) < cmt) ret_m[head + RIDW'(k)] = 1'b1;
    for (int k = 0; k < ENQ_W; k++)
      if (AW'(k) < alloc_eff) alc_m[tail + RIDW'(k)] = 1'b1;
    for (int i = 0; i < ENTRIES; i++)
      sq_m[i] = rob.flush_i && ((RIDW'(i) - head) > fr_off);
  end

  // Pointer and occupancy update; flush recomputes count from survivors.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head <= head + RIDW'(cmt);
      if (rob.flush_i) begin
        tail  <= rob.flush_rid_i + RIDW'(1);
        count <= CW'(fr_off) + CW'(1) - CW'(cmt);
      end else begin
        tail  <= tail + RIDW'(alloc_eff);
        count <= count + CW'(alloc_eff) - CW'(cmt);
      end
    end
  end

  // Entry state: completions land only on valid entries; retire/squash clear; allocate sets valid, clears done.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid <= '0;
      done  <= '0;
    end else begin
      valid <= (valid & ~ret_m & ~sq_m) | alc_m;
      done  <= (done | (rob.done_v_i & valid)) & ~ret_m & ~sq_m & ~alc_m;
    end
  end

`ifdef ANY1_ROB_PERF_EN
  // Running total of retired entries, wraps at 2^64.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) perf_cmt_o <= '0;
    else         perf_cmt_o <= perf_cmt_o + 64'(cmt);
  end
`endif

  // Slot rids and status.
  always_comb begin
    for (int k = 0; k < ENQ_W; k++) rob.alloc_rid_o[k] = tail + RIDW'(k);
    for (int k = 0; k < CMT_W; k++) rob.cmt_rid_o[k]   = head + RIDW'(k);
  end

  assign rob.alloc_gnt_o = gnt;
  assign rob.cmt_cnt_o   = cmt;
  assign rob.empty_o     = (count == '0);
  assign rob.full_o      = (count == CW'(ENTRIES));
  assign rob.count_o     = count;
endmodule

// File: doc/any1_rob_ctrl.md
ANY1_ROB_CTRL -- requirements
Module: any1_rob_ctrl

Interface
REQ-001 SHALL have parameter ENTRIES, default 64, number of reorder entries (power of two, >=4).
REQ-002 SHALL have parameter ENQ_W, default 2, maximum allocations per cycle (1..4).
REQ-003 SHALL have parameter CMT_W, default 2, maximum commits per cycle (1..4).
REQ-004 SHALL derive localparam RIDW = $clog2(ENTRIES); count width RIDW+1.
REQ-005 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-007 SHALL have port alloc_cnt_i  input  $clog2(ENQ_W+1)  entries requested this cycle (0..ENQ_W).
REQ-008 SHALL have port alloc_gnt_o  output  1  request granted this cycle.
REQ-009 SHALL have port alloc_rid_o  output  ENQ_W*RIDW  rids for slots 0..ENQ_W-1, slot k = tail+k mod ENTRIES.
REQ-010 SHALL have port done_v_i  input  ENTRIES  per-entry completion pulses.
REQ-011 SHALL have port cmt_stall_i  input  1  backpressure, blocks commit.
REQ-012 SHALL have port cmt_cnt_o  output  $clog2(CMT_W+1)  entries retiring this cycle.
REQ-013 SHALL have port cmt_rid_o  output  CMT_W*RIDW  rids retiring, slot k = head+k mod ENTRIES.
REQ-014 SHALL have port flush_i  input  1  squash all entries younger than flush_rid_i.
REQ-015 SHALL have port flush_rid_i  input  RIDW  last surviving entry (must be allocated).
REQ-016 SHALL have ports empty_o, full_o  output  1 each; count_o  output  RIDW+1  occupied entries.

Function
REQ-017 SHALL keep registered head, tail (RIDW bits, wrap modulo ENTRIES), count, and per-entry valid and done bits.
REQ-018 SHALL assert alloc_gnt_o combinationally when alloc_cnt_i != 0, flush_i low, and (ENTRIES - count + cmt_cnt_o) >= alloc_cnt_i.
REQ-019 SHALL on grant advance tail by alloc_cnt_i, set valid and clear done for those entries next cycle.
REQ-020 SHALL compute cmt_cnt_o combinationally as number of consecutive valid&done entries from head, capped at CMT_W; zero when cmt_stall_i high.
REQ-021 SHALL on commit advance head by cmt_cnt_o and clear valid/done of retired entries.
REQ-022 SHALL set done bit one cycle after done_v_i pulse; done_v_i for invalid entries SHALL be ignored; earliest commit is the cycle after the done pulse.
REQ-023 SHALL update count = count + granted alloc - cmt_cnt_o each cycle; simultaneous alloc and commit SHALL both apply.
REQ-024 SHALL on flush_i set tail = flush_rid_i+1 mod ENTRIES, clear valid/done of squashed entries, recompute count = (tail_new - head_new) mod ENTRIES, except count = ENTRIES when all entries survive with no commit.
REQ-025 SHALL give flush priority over allocation (no grant in flush cycle); commit in the same cycle SHALL still occur.
REQ-026 SHALL drive empty_o = (count==0), full_o = (count==ENTRIES); head==tail SHALL be disambiguated by count.
REQ-027 SHALL never commit past tail nor allocate over a valid entry.

Reset
REQ-028 SHALL on rst_ni low immediately clear head, tail, count, all valid and done bits.
REQ-029 SHALL drive outputs during and after reset: alloc_gnt_o 0, cmt_cnt_o 0, empty_o 1, full_o 0, count_o 0, rid outputs from head=tail=0.
REQ-030 SHALL abandon any in-flight allocation/commit on reset assertion mid-operation; no partial update after release.

Configuration
REQ-031 SHALL compile a retire-statistics counter when ANY1_ROB_PERF_EN is defined: output perf_cmt_o 64 bits, increments by cmt_cnt_o each cycle, reset to 0, wraps at 2^64.
REQ-032 SHALL omit perf_cmt_o port and counter entirely when ANY1_ROB_PERF_EN is undefined; all other behaviour identical.

Verification
REQ-033 SHALL cover fill: ENTRIES=64, ENQ_W=2, alloc_cnt_i=2 for 32 cycles -> full_o=1, count_o=64, 33rd request alloc_gnt_o=0.
REQ-034 SHALL cover in-order retire: alloc rids 0..3, done_v_i bits 1,0 pulsed -> next cycle cmt_cnt_o=2, cmt_rid_o={1,0}; bit 3 only -> cmt_cnt_o=0 until bit 2 done.
REQ-035 SHALL cover wrap: head=62, tail=62, alloc 4 -> alloc_rid_o={63,62} then {1,0}; all done -> commits 62,63 then 0,1, empty_o=1.
REQ-036 SHALL cover flush: rids 0..9 valid, flush_i with flush_rid_i=4 plus alloc_cnt_i=2 -> alloc_gnt_o=0, next tail=5, count_o=5, done pulses for 5..9 ignored.
REQ-037 SHALL cover full with simultaneous commit: count=64, cmt_cnt_o=2, alloc_cnt_i=2 -> alloc_gnt_o=1, count stays 64.
REQ-038 SHALL cover reset mid-operation: rst_ni low during alloc+commit cycle -> count_o=0, empty_o=1 immediately; perf_cmt_o=0 when ANY1_ROB_PERF_EN defined.
